// File: rtl/mem_port_arbiter.sv
// Shares one single-port instruction/data memory between the Fetch and Memory stages.
// Grants alternate under contention; completed results stay sticky until the owning stage acks.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IReqF,
    input  logic [ADDR_W-1:0] PCF,
    input  logic              AckF,
    input  logic              AbortF,
    input  logic              MemReqM,
    input  logic              MemWriteM,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic              AckM,
    output logic [DATA_W-1:0] InstrF,
    output logic              IReadyF,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              DReadyM,
    output logic              StallF,
    output logic              StallM,
    output logic              MemEn,
    output logic              MemWE,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWD,
    input  logic [DATA_W-1:0] MemRD,
    output logic [15:0]       ConflictCnt
);

    localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_data;
    logic             r_owner_data;
    logic             r_discard;

    logic w_elig_f;
    logic w_elig_d;
    logic w_grant_d;
    logic w_grant_f;
    logic w_done;

    assign w_elig_f  = IReqF & ~IReadyF & ~AbortF;
    assign w_elig_d  = MemReqM & ~DReadyM;
    // Under contention data wins unless it was the previous owner.
    assign w_grant_d = w_elig_d & (~w_elig_f | ~r_last_data);
    assign w_grant_f = w_elig_f & ~w_grant_d;
    assign w_done    = (r_state == S_ACCESS) && (r_cnt == CNT_W'(1));

    assign StallF = IReqF & ~IReadyF;
    assign StallM = MemReqM & ~DReadyM;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_last_data  <= 1'b0;
            r_owner_data <= 1'b0;
            r_discard    <= 1'b0;
            InstrF       <= '0;
            IReadyF      <= 1'b0;
            ReadDataM    <= '0;
            DReadyM      <= 1'b0;
            MemEn        <= 1'b0;
            MemWE        <= 1'b0;
            MemAddr      <= '0;
            MemWD        <= '0;
            ConflictCnt  <= '0;
        end else begin
            if (AckF || AbortF) IReadyF <= 1'b0;
            if (AckM)           DReadyM <= 1'b0;
            MemEn <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_elig_f && w_elig_d && ConflictCnt != 16'hFFFF)
                        ConflictCnt <= ConflictCnt + 16'd1;
                    if (w_grant_d) begin
                        MemAddr      <= ALUResultM;
                        MemWE        <= MemWriteM;
                        MemWD        <= WriteDataM;
                        MemEn        <= 1'b1;
                        r_cnt        <= CNT_W'(LATENCY);
                        r_last_data  <= 1'b1;
                        r_owner_data <= 1'b1;
                        r_state      <= S_ACCESS;
                    end else if (w_grant_f) begin
                        MemAddr      <= PCF;
                        MemWE        <= 1'b0;
                        MemWD        <= WriteDataM;
                        MemEn        <= 1'b1;
                        r_cnt        <= CNT_W'(LATENCY);
                        r_last_data  <= 1'b0;
                        r_owner_data <= 1'b0;
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (!r_owner_data && AbortF) r_discard <= 1'b1;
                    // Completion is ordered after the ack clears so it wins a same-edge ack.
                    if (w_done) begin
                        r_state <= S_IDLE;
                        if (r_owner_data) begin
                            if (!MemWE) ReadDataM <= MemRD;
                            DReadyM <= 1'b1;
                        end else if (r_discard || AbortF) begin
                            r_discard <= 1'b0;
                        end else begin
                            InstrF  <= MemRD;
                            IReadyF <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LATENCY=2 main instance plus a LATENCY=1 instance,
// each backed by a small behavioural memory honouring the read-latency contract.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return 32'hA500_0000 ^ {a[15:0], 16'h1357};
    endfunction

    // ---------------- LATENCY = 2 instance ----------------
    logic        IReqF, AckF, AbortF, MemReqM, MemWriteM, AckM;
    logic [31:0] PCF, ALUResultM, WriteDataM;
    logic [31:0] InstrF, ReadDataM, MemAddr, MemWD, MemRD;
    logic        IReadyF, DReadyM, StallF, StallM, MemEn, MemWE;
    logic [15:0] ConflictCnt;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2)) u0 (
        .clk(clk), .reset(reset),
        .IReqF(IReqF), .PCF(PCF), .AckF(AckF), .AbortF(AbortF),
        .MemReqM(MemReqM), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .AckM(AckM),
        .InstrF(InstrF), .IReadyF(IReadyF), .ReadDataM(ReadDataM), .DReadyM(DReadyM),
        .StallF(StallF), .StallM(StallM),
        .MemEn(MemEn), .MemWE(MemWE), .MemAddr(MemAddr), .MemWD(MemWD), .MemRD(MemRD),
        .ConflictCnt(ConflictCnt)
    );

    logic [31:0] mem0 [256];
    logic        rd_v;
    logic [31:0] rd_d;
    initial for (int i = 0; i < 256; i++) mem0[i] = init_val(32'(i * 4));
    always @(posedge clk) begin
        rd_v <= MemEn & ~MemWE;
        rd_d <= mem0[MemAddr[9:2]];
        if (MemEn && MemWE) mem0[MemAddr[9:2]] <= MemWD;
    end
    assign MemRD = rd_v ? rd_d : 32'hBAD0_BAD0;

    // ---------------- LATENCY = 1 instance ----------------
    logic        IReqF1;
    logic [31:0] PCF1;
    logic [31:0] InstrF1, ReadDataM1, MemAddr1, MemWD1, MemRD1;
    logic        IReadyF1, DReadyM1, StallF1, StallM1, MemEn1, MemWE1;
    logic [15:0] ConflictCnt1;
    logic        zero1 = 1'b0;
    logic [31:0] zero32 = 32'h0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u1 (
        .clk(clk), .reset(reset),
        .IReqF(IReqF1), .PCF(PCF1), .AckF(zero1), .AbortF(zero1),
        .MemReqM(zero1), .MemWriteM(zero1), .ALUResultM(zero32),
        .WriteDataM(zero32), .AckM(zero1),
        .InstrF(InstrF1), .IReadyF(IReadyF1), .ReadDataM(ReadDataM1), .DReadyM(DReadyM1),
        .StallF(StallF1), .StallM(StallM1),
        .MemEn(MemEn1), .MemWE(MemWE1), .MemAddr(MemAddr1), .MemWD(MemWD1), .MemRD(MemRD1),
        .ConflictCnt(ConflictCnt1)
    );
    assign MemRD1 = (MemEn1 && !MemWE1) ? init_val(MemAddr1) : 32'hBAD1_BAD1;

    // ---------------- helpers ----------------
    logic [31:0] exp_q [$];
    logic [31:0] held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        IReqF = 0; AckF = 0; AbortF = 0; MemReqM = 0; MemWriteM = 0; AckM = 0;
        PCF = 0; ALUResultM = 0; WriteDataM = 0; IReqF1 = 0; PCF1 = 0;
        tick(2);
        chk("rst_memen",  {31'b0, MemEn}, 32'h0);
        chk("rst_iready", {31'b0, IReadyF}, 32'h0);
        chk("rst_dready", {31'b0, DReadyM}, 32'h0);
        chk("rst_addr",   MemAddr, 32'h0);
        chk("rst_instr",  InstrF, 32'h0);
        chk("rst_cnt",    {16'b0, ConflictCnt}, 32'h0);
        reset = 1'b0;
        tick();

        // Single fetch
        IReqF = 1; PCF = 32'h10; exp_q.push_back(init_val(32'h10));
        #1 chk("f_stall_c0", {31'b0, StallF}, 32'h1);
        tick();
        chk("f_memen_c1", {31'b0, MemEn}, 32'h1);
        chk("f_addr_c1",  MemAddr, 32'h10);
        chk("f_stall_c1", {31'b0, StallF}, 32'h1);
        tick();
        chk("f_memen_c2", {31'b0, MemEn}, 32'h0);
        chk("f_rdy_c2",   {31'b0, IReadyF}, 32'h0);
        chk("f_stall_c2", {31'b0, StallF}, 32'h1);
        tick();
        chk("f_rdy_c3",   {31'b0, IReadyF}, 32'h1);
        chk("f_instr_c3", InstrF, exp_q.pop_front());
        chk("f_stall_c3", {31'b0, StallF}, 32'h0);
        AckF = 1; IReqF = 0;
        tick();
        chk("f_ackclr", {31'b0, IReadyF}, 32'h0);
        AckF = 0;

        // Conflict: data wins first since last grant was fetch
        IReqF = 1; PCF = 32'h20; MemReqM = 1; MemWriteM = 0; ALUResultM = 32'h80;
        exp_q.push_back(init_val(32'h80));
        exp_q.push_back(init_val(32'h20));
        tick();
        chk("c_first_addr", MemAddr, 32'h80);
        tick(2);
        chk("c_drdy_c3", {31'b0, DReadyM}, 32'h1);
        chk("c_frdy_c3", {31'b0, IReadyF}, 32'h0);
        chk("c_rdata",   ReadDataM, exp_q.pop_front());
        AckM = 1; MemReqM = 0;
        tick();
        AckM = 0;
        chk("c_fgrant_en",   {31'b0, MemEn}, 32'h1);
        chk("c_fgrant_addr", MemAddr, 32'h20);
        chk("c_drdy_clr",    {31'b0, DReadyM}, 32'h0);
        tick();
        chk("c_frdy_c5", {31'b0, IReadyF}, 32'h0);
        tick();
        chk("c_frdy_c6", {31'b0, IReadyF}, 32'h1);
        chk("c_instr",   InstrF, exp_q.pop_front());
        chk("c_cnt",     {16'b0, ConflictCnt}, 32'h1);
        AckF = 1; IReqF = 0;
        tick();
        AckF = 0;

        // Store, with address/data changed after grant
        held = ReadDataM;
        MemReqM = 1; MemWriteM = 1; ALUResultM = 32'h40; WriteDataM = 32'hDEADBEEF;
        tick();
        chk("s_memen", {31'b0, MemEn}, 32'h1);
        chk("s_we_c1", {31'b0, MemWE}, 32'h1);
        chk("s_wd_c1", MemWD, 32'hDEADBEEF);
        ALUResultM = 32'h44; WriteDataM = 32'h0;
        tick();
        chk("s_we_c2",   {31'b0, MemWE}, 32'h1);
        chk("s_wd_c2",   MemWD, 32'hDEADBEEF);
        chk("s_addr_c2", MemAddr, 32'h40);
        tick();
        chk("s_drdy",  {31'b0, DReadyM}, 32'h1);
        chk("s_rdata", ReadDataM, held);
        AckM = 1; MemReqM = 0; MemWriteM = 0;
        tick();
        AckM = 0;
        MemReqM = 1; ALUResultM = 32'h40; exp_q.push_back(32'hDEADBEEF);
        tick(3);
        chk("s_ld_rdy", {31'b0, DReadyM}, 32'h1);
        chk("s_ld_val", ReadDataM, exp_q.pop_front());
        AckM = 1; MemReqM = 0;
        tick();
        AckM = 0;

        // Abort during fetch ACCESS, then a fresh fetch
        held = InstrF;
        IReqF = 1; PCF = 32'h30;
        tick();
        chk("a_memen", {31'b0, MemEn}, 32'h1);
        AbortF = 1;
        tick();
        AbortF = 0; PCF = 32'h34; exp_q.push_back(init_val(32'h34));
        tick();
        chk("a_rdy_c3",   {31'b0, IReadyF}, 32'h0);
        chk("a_instr_c3", InstrF, held);
        chk("a_memen_c3", {31'b0, MemEn}, 32'h0);
        tick();
        chk("a_regrant_en",   {31'b0, MemEn}, 32'h1);
        chk("a_regrant_addr", MemAddr, 32'h34);
        tick(2);
        chk("a_rdy_c6",   {31'b0, IReadyF}, 32'h1);
        chk("a_instr_c6", InstrF, exp_q.pop_front());

        // Sticky hold: AckF low for 4 cycles, no re-grant
        for (int i = 0; i < 4; i++) begin
            chk("h_rdy", {31'b0, IReadyF}, 32'h1);
            chk("h_memen", {31'b0, MemEn}, 32'h0);
            if (i == 3) begin AckF = 1; IReqF = 0; end
            tick();
        end
        chk("h_clr", {31'b0, IReadyF}, 32'h0);
        AckF = 0;

        // Reset in the second ACCESS cycle, then the request completes normally
        MemReqM = 1; MemWriteM = 0; ALUResultM = 32'h84;
        tick(2);
        #2 reset = 1'b1;
        #1;
        chk("r_memen", {31'b0, MemEn}, 32'h0);
        chk("r_addr",  MemAddr, 32'h0);
        chk("r_drdy",  {31'b0, DReadyM}, 32'h0);
        chk("r_rdata", ReadDataM, 32'h0);
        chk("r_instr", InstrF, 32'h0);
        chk("r_cnt",   {16'b0, ConflictCnt}, 32'h0);
        tick();
        reset = 1'b0;
        exp_q.push_back(init_val(32'h84));
        begin
            int n = 0;
            while (!DReadyM && n < 10) begin tick(); n++; end
            chk("r_done_in_time", {31'b0, DReadyM}, 32'h1);
            chk("r_done_cycles", 32'(n), 32'd3);
        end
        chk("r_rdata_after", ReadDataM, exp_q.pop_front());
        AckM = 1; MemReqM = 0;
        tick();
        AckM = 0;

        // LATENCY=1: request at cycle 0, ready at cycle 2
        IReqF1 = 1; PCF1 = 32'h50; exp_q.push_back(init_val(32'h50));
        tick();
        chk("l1_memen_c1", {31'b0, MemEn1}, 32'h1);
        chk("l1_rdy_c1",   {31'b0, IReadyF1}, 32'h0);
        tick();
        chk("l1_rdy_c2",   {31'b0, IReadyF1}, 32'h1);
        chk("l1_instr_c2", InstrF1, exp_q.pop_front());
        IReqF1 = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
